// File: rtl/dds_core.sv
// dds_core: phase-accumulator DDS with serial-loaded FTW / phase offset and a square/triangle/saw/sine mapper.
// Build option DDS_SINE_EN adds a registered quarter-wave sine ROM for mode 3; without it mode 3 outputs triangle.
module dds_core #(
  parameter int unsigned PHASE_LENGTH = 16,
  parameter int unsigned ACC_LENGTH   = 48,
  parameter int unsigned OUT_LENGTH   = 14
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  spi_clk,
  input  logic                  spi_data,
  input  logic                  freq_cs,
  input  logic                  phaseshift_cs,
  input  logic [1:0]            mode_in,
  output logic [OUT_LENGTH-1:0] waveform_out
);

  localparam int unsigned SYNC_W  = 4;
  localparam int unsigned EDGE_W  = 3;
  localparam int unsigned SI_CLK  = 0;
  localparam int unsigned SI_DATA = 1;
  localparam int unsigned SI_FCS  = 2;
  localparam int unsigned SI_PCS  = 3;
  localparam int unsigned EI_CLK  = 0;
  localparam int unsigned EI_FCS  = 1;
  localparam int unsigned EI_PCS  = 2;

  typedef enum logic [1:0] {
    MODE_SQUARE   = 2'd0,
    MODE_TRIANGLE = 2'd1,
    MODE_SAWTOOTH = 2'd2,
    MODE_SINE     = 2'd3
  } mode_e;

  logic [SYNC_W-1:0]       sync1_q, sync1_d;
  logic [SYNC_W-1:0]       sync2_q, sync2_d;
  logic [EDGE_W-1:0]       edge_q, edge_d;
  logic [ACC_LENGTH-1:0]   freq_sr_q, freq_sr_d;
  logic [PHASE_LENGTH-1:0] phase_sr_q, phase_sr_d;
  logic [ACC_LENGTH-1:0]   ftw_q, ftw_d;
  logic [PHASE_LENGTH-1:0] offset_q, offset_d;
  logic [ACC_LENGTH-1:0]   acc_q, acc_d;
  logic [PHASE_LENGTH-1:0] phase_q, phase_d;
  mode_e                   mode_q, mode_d;
  logic [OUT_LENGTH-1:0]   wave_q, wave_d;

  logic                    sclk_s, sdata_s, fcs_s, pcs_s;
  logic                    sclk_rise, fcs_rise, fcs_fall, pcs_rise, pcs_fall;
  logic [ACC_LENGTH-1:0]   fsr_base;
  logic [PHASE_LENGTH-1:0] psr_base;
  logic [PHASE_LENGTH-1:0] phase_c;
  logic                    msb_c;
  logic [OUT_LENGTH-1:0]   square_c, saw_c, tri_raw_c, tri_c;

`ifdef DDS_SINE_EN
  localparam int unsigned ROM_AW = 10;
  localparam int unsigned ROM_DW = OUT_LENGTH - 1;
  localparam int unsigned ROM_N  = 1 << ROM_AW;

  // Quarter-wave entry: (midscale-1)*sin(pi/2*(i+0.5)/N), rounded; half-step offset keeps the mirror symmetric.
  function automatic logic [ROM_DW-1:0] sine_entry(input int unsigned idx);
    real amp;
    real ang;
    amp = real'((1 << ROM_DW) - 1);
    ang = 1.5707963267948966 * (real'(idx) + 0.5) / real'(ROM_N);
    return ROM_DW'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [ROM_DW-1:0] sine_rom [ROM_N];
  for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
    localparam logic [ROM_DW-1:0] ENTRY = sine_entry(gi);
    assign sine_rom[gi] = ENTRY;
  end

  logic [ROM_DW-1:0]     rom_q, rom_d;
  logic [ROM_AW-1:0]     rom_idx_c;
  logic [OUT_LENGTH-1:0] mid_c, rom_ext_c, sine_c;
`endif

  // Synchronized pin copies and their edges
  always_comb begin
    sclk_s    = sync2_q[SI_CLK];
    sdata_s   = sync2_q[SI_DATA];
    fcs_s     = sync2_q[SI_FCS];
    pcs_s     = sync2_q[SI_PCS];
    sclk_rise = sclk_s & ~edge_q[EI_CLK];
    fcs_rise  = fcs_s  & ~edge_q[EI_FCS];
    fcs_fall  = ~fcs_s &  edge_q[EI_FCS];
    pcs_rise  = pcs_s  & ~edge_q[EI_PCS];
    pcs_fall  = ~pcs_s &  edge_q[EI_PCS];
  end

  // Serial link: clear on CS rise, shift on spi_clk rise while selected, commit on CS fall
  always_comb begin
    sync1_d    = {phaseshift_cs, freq_cs, spi_data, spi_clk};
    sync2_d    = sync1_q;
    edge_d     = {pcs_s, fcs_s, sclk_s};
    fsr_base   = fcs_rise ? '0 : freq_sr_q;
    psr_base   = pcs_rise ? '0 : phase_sr_q;
    freq_sr_d  = fsr_base;
    phase_sr_d = psr_base;
    ftw_d      = ftw_q;
    offset_d   = offset_q;
    if (fcs_s && sclk_rise) begin
      freq_sr_d = {fsr_base[ACC_LENGTH-2:0], sdata_s};
    end
    if (pcs_s && sclk_rise) begin
      phase_sr_d = {psr_base[PHASE_LENGTH-2:0], sdata_s};
    end
    if (fcs_fall) begin
      ftw_d = freq_sr_q;
    end
    if (pcs_fall) begin
      offset_d = phase_sr_q;
    end
  end

  // Accumulator and first pipeline stage (phase, mode, ROM lookup)
  always_comb begin
    acc_d   = acc_q + ftw_q;
    phase_c = acc_q[ACC_LENGTH-1 -: PHASE_LENGTH] + offset_q;
    phase_d = phase_c;
    mode_d  = mode_e'(mode_in);
`ifdef DDS_SINE_EN
    rom_idx_c = phase_c[PHASE_LENGTH-2] ? ~phase_c[PHASE_LENGTH-3 -: ROM_AW]
                                        :  phase_c[PHASE_LENGTH-3 -: ROM_AW];
    rom_d     = sine_rom[rom_idx_c];
`endif
  end

  // Second stage: waveform mapper into the output register
  always_comb begin
    msb_c     = phase_q[PHASE_LENGTH-1];
    square_c  = {OUT_LENGTH{msb_c}};
    saw_c     = phase_q[PHASE_LENGTH-1 -: OUT_LENGTH];
    tri_raw_c = phase_q[PHASE_LENGTH-2 -: OUT_LENGTH];
    tri_c     = msb_c ? ~tri_raw_c : tri_raw_c;
`ifdef DDS_SINE_EN
    mid_c     = OUT_LENGTH'(1) << (OUT_LENGTH - 1);
    rom_ext_c = OUT_LENGTH'(rom_q);
    sine_c    = msb_c ? (mid_c - rom_ext_c) : (mid_c + rom_ext_c);
`endif
    wave_d = '0;
    case (mode_q)
      MODE_SQUARE:   wave_d = square_c;
      MODE_TRIANGLE: wave_d = tri_c;
      MODE_SAWTOOTH: wave_d = saw_c;
`ifdef DDS_SINE_EN
      MODE_SINE:     wave_d = sine_c;
`else
      MODE_SINE:     wave_d = tri_c;
`endif
      default:       wave_d = '0;
    endcase
  end

  assign waveform_out = wave_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      edge_q     <= '0;
      freq_sr_q  <= '0;
      phase_sr_q <= '0;
      ftw_q      <= '0;
      offset_q   <= '0;
      acc_q      <= '0;
      phase_q    <= '0;
      mode_q     <= MODE_SQUARE;
      wave_q     <= '0;
`ifdef DDS_SINE_EN
      rom_q      <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      freq_sr_q  <= freq_sr_d;
      phase_sr_q <= phase_sr_d;
      ftw_q      <= ftw_d;
      offset_q   <= offset_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      wave_q     <= wave_d;
`ifdef DDS_SINE_EN
      rom_q      <= rom_d;
`endif
    end
  end

endmodule

// File: tb/tb_dds_core.sv
// tb_dds_core: randomized serial loads and mode changes against a cycle-level arithmetic model of the DDS;
// a monitor compares every output sample, plus a few directed expectations, through queues.
module tb_dds_core;

  localparam int unsigned PH  = 16;
  localparam int unsigned ACC = 48;
  localparam int unsigned OUT = 14;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic           spi_clk;
  logic           spi_data;
  logic           freq_cs;
  logic           phaseshift_cs;
  logic [1:0]     mode_in;
  logic [OUT-1:0] waveform_out;

  dds_core #(.PHASE_LENGTH(PH), .ACC_LENGTH(ACC), .OUT_LENGTH(OUT)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .spi_clk       (spi_clk),
    .spi_data      (spi_data),
    .freq_cs       (freq_cs),
    .phaseshift_cs (phaseshift_cs),
    .mode_in       (mode_in),
    .waveform_out  (waveform_out)
  );

  always #5 sys_clk = ~sys_clk;

  int    checks = 0;
  int    errors = 0;
  int    exp_q[$];
  int    dir_exp[$];
  string dir_name[$];

  // Driver-side view of the shift registers: last N bits sent while selected
  logic [ACC-1:0] m_fsr = '0;
  logic [PH-1:0]  m_psr = '0;

  // Model state
  logic [ACC-1:0] m_acc, m_ftw;
  logic [PH-1:0]  m_off, m_ph1;
  int             m_mode1;
  logic           fh1, fh2, fh3, ph1, ph2, ph3;

  function automatic int ref_wave(input int p, input int mode);
    int half, top;
    half = 1 << (PH - 1);
    top  = (1 << OUT) - 1;
    case (mode)
      0:       return (p >= half) ? top : 0;
      2:       return p >> (PH - OUT);
      default: return (p < half) ? (p >> (PH - 1 - OUT)) : ((((1 << PH) - 1) - p) >> (PH - 1 - OUT));
    endcase
  endfunction

  // Reference: output after edge k maps the phase formed at edge k-1 with the mode sampled at edge k-1;
  // a CS fall is committed three edges after the pin changed (two sync stages plus edge detect).
  always @(posedge sys_clk) begin
    int e;
    if (sys_rst) begin
      m_acc = '0; m_ftw = '0; m_off = '0; m_ph1 = '0; m_mode1 = 0;
      fh1 = 0; fh2 = 0; fh3 = 0; ph1 = 0; ph2 = 0; ph3 = 0;
      e = 0;
    end else begin
      e       = ref_wave(int'(m_ph1), m_mode1);
      m_ph1   = PH'(m_acc >> (ACC - PH)) + m_off;
      m_mode1 = int'(mode_in);
      m_acc   = m_acc + m_ftw;
      if (!fh2 && fh3) m_ftw = m_fsr;
      if (!ph2 && ph3) m_off = m_psr;
      fh3 = fh2; fh2 = fh1; fh1 = freq_cs;
      ph3 = ph2; ph2 = ph1; ph1 = phaseshift_cs;
    end
    exp_q.push_back(e);
  end

  // Monitor: every sample is compared, directed expectations alongside
  always @(negedge sys_clk) begin
    int    e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (waveform_out !== OUT'(e)) begin
        errors++;
        $display("FAIL wave t=%0t got %0d expected %0d", $time, waveform_out, e);
      end
    end
    if (dir_exp.size() > 0) begin
      e = dir_exp.pop_front();
      n = dir_name.pop_front();
      checks++;
      if (waveform_out !== OUT'(e)) begin
        errors++;
        $display("FAIL %s t=%0t got %0d expected %0d", n, $time, waveform_out, e);
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_now(input string name, input int value);
    dir_name.push_back(name);
    dir_exp.push_back(value);
  endtask

  task automatic do_reset(input int k);
    sys_rst = 1'b1;
    cycles(k);
    sys_rst = 1'b0;
  endtask

  // Send the low n bits of val, MSB first, to the selected channel(s)
  task automatic spi_xfer(input bit sel_f, input bit sel_p, input int n, input logic [63:0] val);
    freq_cs       = sel_f;
    phaseshift_cs = sel_p;
    if (sel_f) m_fsr = '0;
    if (sel_p) m_psr = '0;
    cycles(4);
    for (int i = n - 1; i >= 0; i--) begin
      spi_data = val[i];
      cycles(3);
      spi_clk = 1'b1;
      if (sel_f) m_fsr = {m_fsr[ACC-2:0], val[i]};
      if (sel_p) m_psr = {m_psr[PH-2:0], val[i]};
      cycles(3);
      spi_clk = 1'b0;
    end
    cycles(3);
    freq_cs       = 1'b0;
    phaseshift_cs = 1'b0;
    cycles(8);
  endtask

  initial begin
    logic [63:0] v;
    int          sel;
    sys_rst = 1'b1; spi_clk = 1'b0; spi_data = 1'b0;
    freq_cs = 1'b0; phaseshift_cs = 1'b0; mode_in = 2'd0;
    cycles(4);
    expect_now("reset_out", 0);
    sys_rst = 1'b0;
    cycles(5);

    // 44 ones: fast sawtooth
    mode_in = 2'd2;
    v = '0; v[43:0] = '1;
    spi_xfer(1'b1, 1'b0, 44, v);
    cycles(40);

    // Reset mid-stream, output must sit at 0 afterwards
    do_reset(2);
    expect_now("post_reset_a", 0);
    cycles(3);
    expect_now("post_reset_b", 0);
    cycles(20);
    expect_now("post_reset_c", 0);

    // FTW = 2^32 via 33 bits: slow sawtooth
    v = 64'h1_0000_0000;
    spi_xfer(1'b1, 1'b0, 33, v);
    cycles(300);

    // FTW = 2^40: square then triangle
    v = 64'h100_0000_0000;
    spi_xfer(1'b1, 1'b0, 41, v);
    mode_in = 2'd0;
    cycles(300);
    mode_in = 2'd1;
    cycles(300);
    mode_in = 2'd3;
    cycles(50);

    // Frozen accumulator at 0, phase offset only
    mode_in = 2'd2;
    do_reset(2);
    spi_xfer(1'b0, 1'b1, 16, 64'h4000);
    cycles(4);
    expect_now("offset_4000", 4096);
    cycles(10);
    spi_xfer(1'b0, 1'b1, 16, 64'hC000);
    cycles(4);
    expect_now("offset_C000", 12288);
    cycles(10);

    // Overlong freq load keeps the last 48 bits; both channels together
    v = {$urandom, $urandom};
    spi_xfer(1'b1, 1'b0, 60, v);
    cycles(60);
    v = {$urandom, $urandom};
    spi_xfer(1'b1, 1'b1, 48, v);
    cycles(60);

    // Randomized loads, lengths and modes
    for (int it = 0; it < 12; it++) begin
      v   = {$urandom, $urandom};
      sel = int'($urandom_range(1, 3));
      spi_xfer(sel[0], sel[1], int'($urandom_range(1, 64)), v);
      mode_in = 2'($urandom_range(0, 3));
      cycles(int'($urandom_range(20, 120)));
      mode_in = 2'($urandom_range(0, 3));
      cycles(int'($urandom_range(5, 40)));
    end

    cycles(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
